// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART RX frame sequencer. Detects the start edge, runs the
//                oversampling edge counter and data bit counter, enables the
//                start/data/parity/stop checkers and the deserializer in turn,
//                and merges checker errors into a one-cycle data_valid pulse.
//                Optional macro UART_RX_ERR_CNT_EN builds a saturating
//                errored-frame counter on err_cnt_o (constant 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_in_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  par_en_i,
    input  logic                  strt_glitch_i,
    input  logic                  par_err_i,
    input  logic                  stp_err_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [3:0]            bit_cnt_o,
    output logic                  dat_samp_en_o,
    output logic                  strt_chk_en_o,
    output logic                  par_chk_en_o,
    output logic                  stp_chk_en_o,
    output logic                  deser_en_o,
    output logic                  data_valid_o,
    output logic [7:0]            err_cnt_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [3:0]            C_LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] C_ONE      = PRESCALE_W'(1);

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_flag_q, par_flag_d;
    logic                  dv_q, dv_d;
    logic                  bit_end;

    // Last oversample of the current bit period (never asserted in IDLE)
    assign bit_end = (state_q != S_IDLE) && (edge_q == (presc_q - C_ONE));

    // Next-state, counter and prescale-latch logic for the frame sequencer
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        presc_d    = presc_q;
        par_flag_d = par_flag_q;
        dv_d       = 1'b0;
        if (state_q == S_IDLE || bit_end) begin
            edge_d = '0;
        end else begin
            edge_d = edge_q + C_ONE;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_in_i) begin
                    state_d    = S_START;
                    presc_d    = prescale_i;
                    par_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    if (strt_glitch_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == C_LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_i ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_flag_d = par_err_i;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    dv_d = !stp_err_i && !par_flag_q;
                    // A low line on the stop bit's last sample is the next start edge
                    if (!rx_in_i) begin
                        state_d    = S_START;
                        presc_d    = prescale_i;
                        par_flag_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            presc_q    <= '0;
            par_flag_q <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            presc_q    <= presc_d;
            par_flag_q <= par_flag_d;
            dv_q       <= dv_d;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_q;
    logic       err_evt;

    assign err_evt = (state_q == S_STOP) && bit_end && (stp_err_i || par_flag_q);

    // Saturating count of frames that finished STOP with an error
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= '0;
        end else if (err_evt && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = '0;
`endif

    assign edge_cnt_o    = edge_q;
    assign bit_cnt_o     = bit_q;
    assign data_valid_o  = dv_q;
    assign strt_chk_en_o = (state_q == S_START);
    assign par_chk_en_o  = (state_q == S_PARITY);
    assign stp_chk_en_o  = (state_q == S_STOP);
    assign dat_samp_en_o = (state_q == S_START) || (state_q == S_DATA) ||
                           (state_q == S_PARITY) || (state_q == S_STOP);
    assign deser_en_o    = (state_q == S_DATA) && bit_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Self-checking bench for uart_rx_ctrl. Frames are described
//                by their parameters; a timing model derives the expected
//                cycles of each enable / strobe event from the frame length
//                arithmetic and compares them with what the DUT produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic          data_valid;
    logic [7:0]    err_cnt;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_in_i       (rx_in),
        .prescale_i    (prescale),
        .par_en_i      (par_en),
        .strt_glitch_i (strt_glitch),
        .par_err_i     (par_err),
        .stp_err_i     (stp_err),
        .edge_cnt_o    (edge_cnt),
        .bit_cnt_o     (bit_cnt),
        .dat_samp_en_o (dat_samp_en),
        .strt_chk_en_o (strt_chk_en),
        .par_chk_en_o  (par_chk_en),
        .stp_chk_en_o  (stp_chk_en),
        .deser_en_o    (deser_en),
        .data_valid_o  (data_valid),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asrt = 0;
    int n_fail = 0;
    int err_model = 0;
    int g_t0 = 0;

    int exp_deser[$], exp_dv[$], exp_par[$], exp_start[$];
    int act_deser[$], act_dv[$], act_par[$], act_start[$];

    // Observed event log, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (deser_en)                       act_deser.push_back(cyc);
            if (data_valid)                     act_dv.push_back(cyc);
            if (par_chk_en)                     act_par.push_back(cyc);
            if (strt_chk_en && edge_cnt == '0)  act_start.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_err_cnt(input string tag);
        int e;
`ifdef UART_RX_ERR_CNT_EN
        e = (err_model > 255) ? 255 : err_model;
`else
        e = 0;
`endif
        chk(tag, err_cnt, e);
    endtask

    task automatic out_zero(input string tag);
        chk({tag, "_edge"}, edge_cnt, 0);
        chk({tag, "_bit"}, bit_cnt, 0);
        chk({tag, "_en"}, {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en}, 0);
        chk({tag, "_dv"}, data_valid, 0);
    endtask

    task automatic clear_q();
        exp_deser.delete(); exp_dv.delete(); exp_par.delete(); exp_start.delete();
        act_deser.delete(); act_dv.delete(); act_par.delete(); act_start.delete();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_deser_n"}, act_deser.size(), exp_deser.size());
        for (int i = 0; i < act_deser.size() && i < exp_deser.size(); i++)
            chk({tag, "_deser_t"}, act_deser[i], exp_deser[i]);
        chk({tag, "_dv_n"}, act_dv.size(), exp_dv.size());
        for (int i = 0; i < act_dv.size() && i < exp_dv.size(); i++)
            chk({tag, "_dv_t"}, act_dv[i], exp_dv[i]);
        chk({tag, "_par_n"}, act_par.size(), exp_par.size());
        for (int i = 0; i < act_par.size() && i < exp_par.size(); i++)
            chk({tag, "_par_t"}, act_par[i], exp_par[i]);
        chk({tag, "_start_n"}, act_start.size(), exp_start.size());
        for (int i = 0; i < act_start.size() && i < exp_start.size(); i++)
            chk({tag, "_start_t"}, act_start[i], exp_start[i]);
        clear_q();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_in = 1'b1;
        end
    endtask

    // Drive one frame waveform starting with the falling start edge (cycle t0)
    // and record the model's expected event cycles. ncyc<0 drives the whole
    // frame; a glitch keeps rx low only for the start bit.
    task automatic send_frame(input int p, input int pn, input bit pe,
                              input logic [8:0] d, input bit perr, input bit serr,
                              input bit glitch, input int ncyc);
        int   nb, len, t0;
        logic bits [12];
        nb  = 2 + DW + int'(pe);
        len = nb * p;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = d[i];
        bits[DW+1]  = ^d[DW-1:0];
        bits[nb-1]  = 1'b1;
        for (int c = 0; c < len && (ncyc < 0 || c < ncyc); c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                t0       = cyc;
                g_t0     = t0;
                prescale = PW'(p);
                par_en   = pe;
                exp_start.push_back(t0 + 1);
                if (!glitch) begin
                    for (int k = 0; k < DW; k++) exp_deser.push_back(t0 + (k + 2) * p);
                    if (pe)
                        for (int t = t0 + (DW + 1) * p + 1; t <= t0 + (DW + 2) * p; t++)
                            exp_par.push_back(t);
                    if (serr || (pe && perr)) err_model++;
                    else                      exp_dv.push_back(t0 + len + 1);
                end
            end
            if (c == 1) begin
                par_err     = perr;
                stp_err     = serr;
                strt_glitch = glitch;
            end
            if (c == len / 2) prescale = PW'(pn);
            rx_in = (glitch && c >= p) ? 1'b1 : bits[c / p];
        end
    endtask

    initial begin
        int p, pn, gap;
        bit pe, pr, sr;
        reset = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        out_zero("reset");
        chk("reset_err", err_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(4);

        // Clean 0xA5 frame, prescale 8, no parity
        send_frame(8, 8, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        chk("a5_dv_at81", (act_dv.size() > 0) ? act_dv[0] - g_t0 : -1, 81);
        chk("a5_deser_first", (act_deser.size() > 0) ? act_deser[0] - g_t0 : -1, 16);
        @(negedge clk);
        out_zero("a5_idle");
        compare_all("a5");
        chk_err_cnt("a5_err");

        // Parity frame: par_chk_en window then data_valid at t0+89
        send_frame(8, 8, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        chk("par_dv_at89", (act_dv.size() > 0) ? act_dv[0] - g_t0 : -1, 89);
        chk("par_win_first", (act_par.size() > 0) ? act_par[0] - g_t0 : -1, 73);
        compare_all("par");

        // Stop error at prescale 16
        send_frame(16, 16, 1'b0, 9'h05A, 1'b0, 1'b1, 1'b0, -1);
        idle(20);
        compare_all("stperr");
        chk_err_cnt("stperr_err");

        // Start glitch: back to IDLE right after the start bit
        send_frame(8, 8, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9);
        @(posedge clk); #1;
        rx_in = 1'b1;
        @(negedge clk);
        chk("glitch_idle_t", cyc - g_t0, 9);
        out_zero("glitch_idle");
        idle(30);
        compare_all("glitch");
        chk_err_cnt("glitch_err");

        // Back-to-back frames at prescale 8
        send_frame(8, 8, 1'b0, 9'h011, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8, 8, 1'b0, 9'h0EE, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        chk("b2b_dv_gap", (act_dv.size() == 2) ? act_dv[1] - act_dv[0] : -1, 80);
        compare_all("b2b");

        // Back-to-back with prescale changed 8->16 mid first frame
        send_frame(8, 16, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0, -1);
        send_frame(16, 16, 1'b1, 9'h07E, 1'b1, 1'b0, 1'b0, -1);
        idle(20);
        compare_all("b2b_ps");
        chk_err_cnt("b2b_ps_err");

        // Reset during DATA at bit_cnt 3
        send_frame(8, 8, 1'b0, 9'h099, 1'b0, 1'b0, 1'b0, 36);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_bitcnt", bit_cnt, 3);
        chk("mid_deser_n", act_deser.size(), 3);
        @(posedge clk); #1;
        reset = 1'b0; rx_in = 1'b1;
        @(negedge clk);
        out_zero("mid_rst");
        chk("mid_rst_err", err_cnt, 0);
        clear_q();
        err_model = 0;
        idle(3);
        send_frame(8, 8, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        chk("post_rst_dv_at81", (act_dv.size() > 0) ? act_dv[0] - g_t0 : -1, 81);
        compare_all("post_rst");

        // Randomized frame stream
        for (int f = 0; f < 10; f++) begin
            p   = 8 << $urandom_range(0, 2);
            pn  = 8 << $urandom_range(0, 2);
            pe  = 1'($urandom_range(0, 1));
            pr  = ($urandom_range(0, 3) == 0);
            sr  = ($urandom_range(0, 3) == 0);
            send_frame(p, pn, pe, 9'($urandom), pr, sr, 1'b0, -1);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
        end
        idle(40);
        compare_all("rand");
        chk_err_cnt("rand_err");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
